// File: rtl/fp_ooo_hub.sv
// ---------------------------------------------------------------------------
// fp_ooo_hub
//
// Purpose:
//   Sequential floating-point hub sitting between FPU decode and FP register
//   writeback. Every accepted operation is given a tag, which is an entry in a
//   DEPTH-entry in-order completion buffer.
//   - Single-cycle ops (req_comb = 1) carry their result with the request, so
//     they are complete as soon as they are allocated.
//   - Multi-cycle ops are dispatched to one of NUM_UNITS execution units. The
//     units may return results out of order, tagged with the entry index.
//   Results always retire in allocation order through a valid/ready port.
//
// Handshake rules (all three ports):
//   A transfer happens in a cycle where valid && ready are both 1 at the
//   rising clock edge. req_ready does not depend on req_valid. out_valid,
//   out_result and out_flags depend only on registered state, so they hold
//   stable while out_ready is 0. disp_valid[i] is a strobe: the unit must
//   take the op whenever it is high, which is only possible while
//   unit_ready[i] is 1.
//
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   clear                 synchronous flush; beats requests and writebacks
//   req_*                 operation request (comb result/flags, target unit)
//   disp_valid, disp_tag  one-hot dispatch strobe and the tag it carries
//   unit_ready            per-unit accept capability
//   wb_valid/tag/result/flags  per-unit writeback, packed unit-major
//   out_*                 in-order retire port
//   occupancy, busy       number of allocated entries, and occupancy != 0
//   err                   sticky protocol error
//
// Optional feature:
//   FP_OOO_HUB_ERR_CHECK_EN - when defined, err flags writebacks to invalid or
//   already-done entries, equal tags written back in the same cycle, and
//   out_ready raised on an empty hub while a comb op is being requested.
//   When undefined, err is tied to 0 and no check logic exists.
// ---------------------------------------------------------------------------
module fp_ooo_hub #(
    parameter  int DATA_W    = 64,
    parameter  int FLAG_W    = 5,
    parameter  int DEPTH     = 4,
    parameter  int NUM_UNITS = 4,
    localparam int TAG_W     = $clog2(DEPTH),
    localparam int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_comb,
    input  logic [DATA_W-1:0]         req_comb_result,
    input  logic [FLAG_W-1:0]         req_comb_flags,
    input  logic [UNIT_W-1:0]         req_unit,

    output logic [NUM_UNITS-1:0]      disp_valid,
    output logic [TAG_W-1:0]          disp_tag,
    input  logic [NUM_UNITS-1:0]      unit_ready,

    input  logic [NUM_UNITS-1:0]      wb_valid,
    input  logic [NUM_UNITS*TAG_W-1:0]  wb_tag,
    input  logic [NUM_UNITS*DATA_W-1:0] wb_result,
    input  logic [NUM_UNITS*FLAG_W-1:0] wb_flags,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_result,
    output logic [FLAG_W-1:0]         out_flags,

    output logic [TAG_W:0]            occupancy,
    output logic                      busy,
    output logic                      err
);

    // -----------------------------------------------------------------------
    // Completion buffer state
    // -----------------------------------------------------------------------
    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits match.
    logic [TAG_W:0]       r_wr_ptr;
    logic [TAG_W:0]       r_rd_ptr;
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_done;
    logic [DATA_W-1:0]    r_result [DEPTH];
    logic [FLAG_W-1:0]    r_flags  [DEPTH];

    logic [TAG_W-1:0]     w_wr_idx;
    logic [TAG_W-1:0]     w_rd_idx;
    logic                 w_full;
    logic                 w_unit_rdy;
    logic                 w_accept;
    logic                 w_dispatch;
    logic                 w_retire;

    // Unpacked views of the packed writeback buses.
    logic [TAG_W-1:0]     w_wb_tag    [NUM_UNITS];
    logic [DATA_W-1:0]    w_wb_result [NUM_UNITS];
    logic [FLAG_W-1:0]    w_wb_flags  [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_wb_hit;

    assign w_wr_idx = r_wr_ptr[TAG_W-1:0];
    assign w_rd_idx = r_rd_ptr[TAG_W-1:0];
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[TAG_W] != r_rd_ptr[TAG_W]);

    // Readiness of the addressed unit. Built by comparison rather than by
    // indexing so that a req_unit beyond NUM_UNITS-1 simply reads as not
    // ready when NUM_UNITS is not a power of two.
    always_comb begin
        w_unit_rdy = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (req_unit == UNIT_W'(i)) begin
                w_unit_rdy = unit_ready[i];
            end
        end
    end

    // Fullness comes from registered pointers only: a retire in the same
    // cycle does not open a slot for this cycle's request.
    assign req_ready  = !clear && !w_full && (req_comb || w_unit_rdy);
    assign w_accept   = req_valid && req_ready;
    assign w_dispatch = w_accept && !req_comb;

    always_comb begin
        disp_valid = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            disp_valid[i] = w_dispatch && (req_unit == UNIT_W'(i));
        end
    end
    assign disp_tag = w_wr_idx;

    // -----------------------------------------------------------------------
    // Writeback decode
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_wb_unpack
        assign w_wb_tag[g]    = wb_tag[g*TAG_W +: TAG_W];
        assign w_wb_result[g] = wb_result[g*DATA_W +: DATA_W];
        assign w_wb_flags[g]  = wb_flags[g*FLAG_W +: FLAG_W];
        // Only a pending entry (valid, not yet done) accepts a writeback.
        assign w_wb_hit[g]    = wb_valid[g] && r_valid[w_wb_tag[g]] && !r_done[w_wb_tag[g]];
    end

    // -----------------------------------------------------------------------
    // Retire port: head entry, purely from registered state
    // -----------------------------------------------------------------------
    assign out_valid  = r_valid[w_rd_idx] && r_done[w_rd_idx];
    assign out_result = r_result[w_rd_idx];
    assign out_flags  = r_flags[w_rd_idx];
    assign w_retire   = out_valid && out_ready;

    assign occupancy  = r_wr_ptr - r_rd_ptr;
    assign busy       = (occupancy != '0);

    // -----------------------------------------------------------------------
    // Control state: pointers plus per-entry valid/done
    // -----------------------------------------------------------------------
    // Allocate, retire and writeback never touch the same entry in one cycle:
    // allocation targets an invalid slot, retire needs a done head, and a
    // writeback needs a valid entry that is not done.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
            r_done   <= '0;
        end else begin
            if (w_accept) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_done[w_wr_idx]  <= req_comb;
                r_wr_ptr          <= r_wr_ptr + (TAG_W+1)'(1);
            end
            if (w_retire) begin
                r_valid[w_rd_idx] <= 1'b0;
                r_done[w_rd_idx]  <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + (TAG_W+1)'(1);
            end
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_wb_hit[i]) begin
                    r_done[w_wb_tag[i]] <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Payload storage
    // -----------------------------------------------------------------------
    // Payload is only observable through an entry whose valid/done bits say
    // it was written, so it needs no reset. Writes are still suppressed under
    // reset/clear so a flushed request cannot leave stale data behind.
    always_ff @(posedge clock) begin
        if (!reset && !clear) begin
            if (w_accept && req_comb) begin
                r_result[w_wr_idx] <= req_comb_result;
                r_flags[w_wr_idx]  <= req_comb_flags;
            end
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_wb_hit[i]) begin
                    r_result[w_wb_tag[i]] <= w_wb_result[i];
                    r_flags[w_wb_tag[i]]  <= w_wb_flags[i];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Protocol error detection
    // -----------------------------------------------------------------------
`ifdef FP_OOO_HUB_ERR_CHECK_EN
    logic r_err;
    logic w_err_evt;

    always_comb begin
        w_err_evt = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            // Writeback to a free slot or to one that already completed.
            if (wb_valid[i] && (!r_valid[w_wb_tag[i]] || r_done[w_wb_tag[i]])) begin
                w_err_evt = 1'b1;
            end
            // Two units claiming the same tag in one cycle.
            for (int j = i + 1; j < NUM_UNITS; j++) begin
                if (wb_valid[i] && wb_valid[j] && (w_wb_tag[i] == w_wb_tag[j])) begin
                    w_err_evt = 1'b1;
                end
            end
        end
        // The consumer is expecting a same-cycle comb bypass, which this hub
        // does not provide: a comb result appears one cycle after accept.
        if (out_ready && !out_valid && (occupancy == '0) && req_valid && req_comb) begin
            w_err_evt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_ooo_hub.sv
// ---------------------------------------------------------------------------
// tb_fp_ooo_hub
//
// Self-checking bench for fp_ooo_hub with default parameters (DATA_W 64,
// FLAG_W 5, DEPTH 4, NUM_UNITS 4). Inputs change 1 ns after the rising edge
// and outputs are compared 1 ns later, well away from the next edge.
// Directed scenarios cover reset, comb latency, out-of-order completion,
// full/wrap, output hold, clear and the error flag; a randomized run checks
// everything against a queue-of-operations model of the hub.
// ---------------------------------------------------------------------------
module tb_fp_ooo_hub;

    localparam int DATA_W    = 64;
    localparam int FLAG_W    = 5;
    localparam int DEPTH     = 4;
    localparam int NUM_UNITS = 4;
    localparam int TAG_W     = 2;
    localparam int UNIT_W    = 2;

    // -----------------------------------------------------------------------
    // Clock / reset and DUT
    // -----------------------------------------------------------------------
    logic                        clock = 1'b0;
    logic                        reset;
    logic                        clear;
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_comb;
    logic [DATA_W-1:0]           req_comb_result;
    logic [FLAG_W-1:0]           req_comb_flags;
    logic [UNIT_W-1:0]           req_unit;
    logic [NUM_UNITS-1:0]        disp_valid;
    logic [TAG_W-1:0]            disp_tag;
    logic [NUM_UNITS-1:0]        unit_ready;
    logic [NUM_UNITS-1:0]        wb_valid;
    logic [NUM_UNITS*TAG_W-1:0]  wb_tag;
    logic [NUM_UNITS*DATA_W-1:0] wb_result;
    logic [NUM_UNITS*FLAG_W-1:0] wb_flags;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_result;
    logic [FLAG_W-1:0]           out_flags;
    logic [TAG_W:0]              occupancy;
    logic                        busy;
    logic                        err;

    always #5 clock = ~clock;

    fp_ooo_hub #(
        .DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .NUM_UNITS(NUM_UNITS)
    ) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_comb(req_comb),
        .req_comb_result(req_comb_result), .req_comb_flags(req_comb_flags),
        .req_unit(req_unit),
        .disp_valid(disp_valid), .disp_tag(disp_tag), .unit_ready(unit_ready),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_result(wb_result), .wb_flags(wb_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags),
        .occupancy(occupancy), .busy(busy), .err(err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard of results expected on the retire port, in order.
    logic [DATA_W-1:0] exp_q[$];

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        clear           = 1'b0;
        req_valid       = 1'b0;
        req_comb        = 1'b0;
        req_comb_result = '0;
        req_comb_flags  = '0;
        req_unit        = '0;
        unit_ready      = '0;
        wb_valid        = '0;
        wb_tag          = '0;
        wb_result       = '0;
        wb_flags        = '0;
        out_ready       = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive_req(input bit comb, input int unit,
                             input logic [DATA_W-1:0] res, input logic [FLAG_W-1:0] flg);
        req_valid       = 1'b1;
        req_comb        = comb;
        req_unit        = UNIT_W'(unit);
        req_comb_result = res;
        req_comb_flags  = flg;
    endtask

    task automatic drive_wb(input int unit, input int tag,
                            input logic [DATA_W-1:0] res, input logic [FLAG_W-1:0] flg);
        logic [TAG_W-1:0] t;
        t = TAG_W'(tag);
        wb_valid[unit]                  = 1'b1;
        wb_tag[unit*TAG_W +: TAG_W]     = t;
        wb_result[unit*DATA_W +: DATA_W] = res;
        wb_flags[unit*FLAG_W +: FLAG_W] = flg;
    endtask

    // Retire whatever the scoreboard expects, bounded by a cycle budget.
    task automatic drain_check(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                n_cmp++;
                if (out_result !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL %s_order: got %0h want %0h", name, out_result, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            step();
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d results never retired, want 0", name, exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (occupancy !== 3'd0) begin n_err++; $display("FAIL %s_empty: occupancy %0d want 0", name, occupancy); end
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        req_comb = 1'b1;
        #1;
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0)       begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (disp_valid !== 4'b0) begin n_err++; $display("FAIL reset_disp: got %b want 0", disp_valid); end
        drive_idle();
    endtask

    task automatic test_comb_latency();
        do_reset();
        out_ready = 1'b1;
        drive_req(1'b1, 0, 64'h3FF0_0000_0000_0000, 5'h00);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL comb_ready: got %b want 1", req_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL comb_no_bypass: got %b want 0", out_valid); end
        step();
        req_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL comb_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 64'h3FF0_0000_0000_0000) begin n_err++; $display("FAIL comb_result: got %h want 3ff0000000000000", out_result); end
        n_cmp++; if (out_flags !== 5'h00) begin n_err++; $display("FAIL comb_flags: got %h want 0", out_flags); end
        n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL comb_occ1: got %0d want 1", occupancy); end
        step();
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL comb_occ0: got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL comb_out_gone: got %b want 0", out_valid); end
        drive_idle();
    endtask

    task automatic test_out_of_order();
        do_reset();
        unit_ready = 4'hF;
        out_ready  = 1'b1;
        drive_req(1'b0, 0, '0, '0);
        #1;
        n_cmp++; if (disp_valid !== 4'b0001) begin n_err++; $display("FAIL ooo_disp_a: got %b want 0001", disp_valid); end
        n_cmp++; if (disp_tag !== 2'd0)      begin n_err++; $display("FAIL ooo_tag_a: got %0d want 0", disp_tag); end
        step();
        drive_req(1'b0, 1, '0, '0);
        #1;
        n_cmp++; if (disp_valid !== 4'b0010) begin n_err++; $display("FAIL ooo_disp_b: got %b want 0010", disp_valid); end
        n_cmp++; if (disp_tag !== 2'd1)      begin n_err++; $display("FAIL ooo_tag_b: got %0d want 1", disp_tag); end
        step();
        req_valid = 1'b0;
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h2);
        drive_wb(1, 1, 64'h2, 5'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ooo_early_out: cycle %0d got %b want 0", c, out_valid); end
            step();
            wb_valid = '0;
            if (c == 1) drive_wb(0, 0, 64'h1, 5'h0);
        end
        wb_valid = '0;
        drain_check("ooo", 8);
        drive_idle();
    endtask

    task automatic test_full_wrap();
        do_reset();
        unit_ready = 4'hF;
        out_ready  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive_req(1'b0, k, '0, '0);
            #1;
            n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d: got %b want 1", k, req_ready); end
            n_cmp++; if (disp_tag !== TAG_W'(k)) begin n_err++; $display("FAIL full_tag_%0d: got %0d want %0d", k, disp_tag, k); end
            step();
        end
        drive_req(1'b0, 0, '0, '0);
        #1;
        n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_not_ready: got %b want 0", req_ready); end
        n_cmp++; if (disp_valid !== 4'b0) begin n_err++; $display("FAIL full_no_disp: got %b want 0", disp_valid); end
        drive_wb(0, 0, 64'hA0, 5'h0);
        step();
        wb_valid  = '0;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (out_result !== 64'hA0) begin n_err++; $display("FAIL full_head: got %h want a0", out_result); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_retire_no_slot: got %b want 0", req_ready); end
        step();
        out_ready = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL full_after_retire: got %0d want 3", occupancy); end
        n_cmp++; if (disp_tag !== 2'd0)  begin n_err++; $display("FAIL full_wrap_tag: got %0d want 0", disp_tag); end
        n_cmp++; if (disp_valid !== 4'b0001) begin n_err++; $display("FAIL full_wrap_disp: got %b want 0001", disp_valid); end
        step();
        req_valid = 1'b0;
        for (int u = 1; u < NUM_UNITS; u++) begin
            drive_wb(u, u, 64'hA0 + 64'(u), 5'(u));
            exp_q.push_back(64'hA0 + 64'(u));
        end
        drive_wb(0, 0, 64'hA4, 5'h4);
        exp_q.push_back(64'hA4);
        step();
        wb_valid  = '0;
        out_ready = 1'b1;
        drain_check("full", 10);
        drive_idle();
    endtask

    task automatic test_hold();
        logic [DATA_W-1:0] r;
        do_reset();
        r = {$urandom, $urandom};
        out_ready = 1'b0;
        drive_req(1'b1, 0, r, 5'h10);
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid_%0d: got %b want 1", c, out_valid); end
            n_cmp++; if (out_result !== r)   begin n_err++; $display("FAIL hold_result_%0d: got %h want %h", c, out_result, r); end
            n_cmp++; if (out_flags !== 5'h10) begin n_err++; $display("FAIL hold_flags_%0d: got %h want 10", c, out_flags); end
            step();
        end
        n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL hold_occ: got %0d want 1", occupancy); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL hold_retired: occupancy %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_out_gone: got %b want 0", out_valid); end
        drive_idle();
    endtask

    task automatic test_clear();
        do_reset();
        unit_ready = 4'hF;
        for (int k = 0; k < 3; k++) begin
            drive_req(1'b0, k, '0, '0);
            step();
        end
        clear = 1'b1;
        drive_req(1'b0, 3, '0, '0);
        drive_wb(0, 0, 64'h55, 5'h1);
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready: got %b want 0", req_ready); end
        n_cmp++; if (disp_valid !== 4'b0) begin n_err++; $display("FAIL clear_disp: got %b want 0", disp_valid); end
        step();
        clear    = 1'b0;
        wb_valid = '0;
        #1;
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL clear_occ: got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (disp_tag !== 2'd0)  begin n_err++; $display("FAIL clear_new_tag: got %0d want 0", disp_tag); end
        n_cmp++; if (disp_valid !== 4'b1000) begin n_err++; $display("FAIL clear_new_disp: got %b want 1000", disp_valid); end
        step();
        req_valid = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL clear_occ_after: got %0d want 1", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_wb_dropped: got %b want 0", out_valid); end
        drive_idle();
    endtask

    task automatic test_err();
        logic exp_err;
`ifdef FP_OOO_HUB_ERR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        drive_wb(2, 2, 64'h9, 5'h0);
        step();
        wb_valid = '0;
        #1;
        n_cmp++; if (err !== exp_err) begin n_err++; $display("FAIL err_set: got %b want %b", err, exp_err); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL err_wb_ignored: occupancy %0d want 0", occupancy); end
        step();
        step();
        n_cmp++; if (err !== exp_err) begin n_err++; $display("FAIL err_sticky: got %b want %b", err, exp_err); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b want 0", err); end
        drive_idle();
    endtask

    // Randomized traffic against a model that holds the outstanding
    // operations as a list in issue order.
    typedef struct {
        int                tag;
        int                unit;
        bit                done;
        logic [DATA_W-1:0] res;
        logic [FLAG_W-1:0] flg;
    } op_t;

    task automatic test_random();
        op_t               mq[$];
        int                alloc_n;
        int                wb_idx[$];
        int                cand[$];
        bit                feed;
        bit                exp_rdy;
        bit                exp_ov;
        logic [NUM_UNITS-1:0] exp_disp;
        logic [DATA_W-1:0] r;
        logic [FLAG_W-1:0] f;
        int                pick;

        do_reset();
        alloc_n = 0;
        for (int cyc = 0; cyc < 1700; cyc++) begin
            feed = (cyc < 1500);
            drive_idle();
            if (feed && $urandom_range(0, 2) != 0) begin
                drive_req($urandom_range(0, 3) == 0, $urandom_range(0, NUM_UNITS-1),
                          {$urandom, $urandom}, 5'($urandom_range(0, 31)));
            end
            unit_ready = 4'($urandom_range(0, 15));
            out_ready  = feed ? ($urandom_range(0, 3) != 0) : 1'b1;

            // Each unit may return one of its in-flight ops, in any order.
            wb_idx.delete();
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (!feed || $urandom_range(0, 2) == 0) begin
                    cand.delete();
                    foreach (mq[j]) if (!mq[j].done && mq[j].unit == u) cand.push_back(j);
                    if (cand.size() > 0) begin
                        pick = cand[$urandom_range(0, cand.size()-1)];
                        r = {$urandom, $urandom};
                        f = 5'($urandom_range(0, 31));
                        drive_wb(u, mq[pick].tag, r, f);
                        mq[pick].res = r;
                        mq[pick].flg = f;
                        wb_idx.push_back(pick);
                    end
                end
            end
            #1;

            exp_rdy  = (mq.size() < DEPTH) && (req_comb || unit_ready[req_unit]);
            exp_disp = '0;
            if (req_valid && !req_comb && exp_rdy) exp_disp[req_unit] = 1'b1;
            exp_ov   = (mq.size() > 0) && mq[0].done;

            n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, req_ready, exp_rdy); end
            n_cmp++; if (disp_valid !== exp_disp) begin n_err++; $display("FAIL rand_disp@%0d: got %b want %b", cyc, disp_valid, exp_disp); end
            if (exp_disp != '0) begin
                n_cmp++; if (disp_tag !== TAG_W'(alloc_n % DEPTH)) begin n_err++; $display("FAIL rand_tag@%0d: got %0d want %0d", cyc, disp_tag, alloc_n % DEPTH); end
            end
            n_cmp++; if (occupancy !== 3'(mq.size())) begin n_err++; $display("FAIL rand_occ@%0d: got %0d want %0d", cyc, occupancy, mq.size()); end
            n_cmp++; if (out_valid !== exp_ov) begin n_err++; $display("FAIL rand_out_valid@%0d: got %b want %b", cyc, out_valid, exp_ov); end
            if (exp_ov) begin
                n_cmp++; if (out_result !== mq[0].res) begin n_err++; $display("FAIL rand_result@%0d: got %h want %h", cyc, out_result, mq[0].res); end
                n_cmp++; if (out_flags !== mq[0].flg)  begin n_err++; $display("FAIL rand_flags@%0d: got %h want %h", cyc, out_flags, mq[0].flg); end
            end

            // Model update for the coming edge: completions, retire, allocate.
            foreach (wb_idx[k]) mq[wb_idx[k]].done = 1'b1;
            if (exp_ov && out_ready) void'(mq.pop_front());
            if (req_valid && exp_rdy) begin
                mq.push_back('{tag: alloc_n % DEPTH, unit: int'(req_unit), done: req_comb,
                               res: req_comb_result, flg: req_comb_flags});
                alloc_n++;
            end
            step();
        end
        n_cmp++; if (mq.size() != 0) begin n_err++; $display("FAIL rand_drain: %0d ops left, want 0", mq.size()); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rand_final_occ: got %0d want 0", occupancy); end
        drive_idle();
    endtask

    // -----------------------------------------------------------------------
    // Sequence and final report
    // -----------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_comb_latency();
        test_out_of_order();
        test_full_wrap();
        test_hold();
        test_clear();
        test_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_ooo_hub.md
Name: fp_ooo_hub

Overview:
- Parametrised sequential successor to the combinational floating-point hub.
- Accepts one FP operation per cycle and allocates it a tag in a DEPTH-entry in-order completion buffer.
- Dispatches multi-cycle ops (fma/fdiv/cvt class) to NUM_UNITS execution units, which may return results out of order.
- Retires results strictly in issue order through a valid/ready output with back-pressure. Sits between FPU decode and FP register writeback.

Parameters:
- DATA_W, 64: result width.
- FLAG_W, 5: exception flag width (NV DZ OF UF NX).
- DEPTH, 4: completion buffer entries; power of two, at least 2. TAG_W = clog2(DEPTH).
- NUM_UNITS, 4: number of multi-cycle execution units. UNIT_W = clog2(NUM_UNITS), minimum 1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous flush; units are flushed by the same signal.
- req_valid  in  1  operation request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_comb  in  1  op is single-cycle (cmp/sgnj/max/class/mv); its result is supplied with the request.
- req_comb_result  in  DATA_W  result of a comb op.
- req_comb_flags  in  FLAG_W  flags of a comb op.
- req_unit  in  UNIT_W  target unit index for a non-comb op.
- disp_valid  out  NUM_UNITS  one-hot dispatch strobe.
- disp_tag  out  TAG_W  tag given to the dispatched op.
- unit_ready  in  NUM_UNITS  unit can accept an op this cycle.
- wb_valid  in  NUM_UNITS  unit writeback strobes.
- wb_tag  in  NUM_UNITS*TAG_W  packed tags; unit i occupies bits [i*TAG_W +: TAG_W].
- wb_result  in  NUM_UNITS*DATA_W  packed results.
- wb_flags  in  NUM_UNITS*FLAG_W  packed flags.
- out_valid  out  1  head entry is complete.
- out_ready  in  1  consumer accepts.
- out_result  out  DATA_W  head result.
- out_flags  out  FLAG_W  head flags.
- occupancy  out  TAG_W+1  allocated entries.
- busy  out  1  occupancy != 0.
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset and clear: all entries invalid, wr_ptr = rd_ptr = 0, occupancy = 0, out_valid = 0, busy = 0, err = 0. clear has priority over every same-cycle event: a request or writeback in that cycle is dropped, and req_ready is 0 while clear = 1.
- Each entry holds valid, done, result and flags.
- Pointers are TAG_W+1 bits. Index = low TAG_W bits. full when the index bits are equal and the MSBs differ; empty when the pointers are equal.
- req_ready = !clear && !full && (req_comb || unit_ready[req_unit]). It is combinational and must not depend on req_valid.
- Dispatch: disp_valid[req_unit] = req_valid && !req_comb && !full && !clear && unit_ready[req_unit]. disp_tag = wr_ptr index.
- On accept, entry[wr_ptr] gets valid = 1 and done = req_comb. A comb op also stores its result and flags. wr_ptr then increments and wraps modulo 2*DEPTH.
- Writeback: for each i with wb_valid[i], entry[wb_tag_i] gets done = 1 plus the result and flags, provided the entry is valid and not done; otherwise the writeback is ignored. Multiple units writing distinct tags in the same cycle are all captured. Units must never return the same tag twice.
- Retire: out_valid = entry[rd_ptr].valid && entry[rd_ptr].done, and out_result/out_flags come from the head entry, all combinational from registered state. On out_valid && out_ready the head is invalidated and rd_ptr increments.
- Latency:
  - comb op accepted in cycle N → out_valid in N+1 if it is the head.
  - unit writeback in cycle M → out_valid in M+1 if it is the head.
- Out-of-order completion: a done entry behind a pending head waits. Output order is always allocation order.
- Full buffer: a retire in the same cycle does not free a slot for that cycle's request; req_ready is computed from registered occupancy.
- Same-cycle allocate and retire: occupancy is unchanged.
- out_valid with out_ready = 0: output holds stable.

Optional Feature:
- Macro FP_OOO_HUB_ERR_CHECK_EN.
- Defined: err is set (sticky until reset/clear) on any of:
  - writeback to an invalid entry;
  - writeback to an already-done entry;
  - two wb_valid in the same cycle carrying equal tags;
  - out_ready sampled while out_valid = 0 and occupancy = 0 with req_valid = 1 and req_comb = 1 (comb-bypass misuse check).
- Not defined: err is tied to 0 and no check logic is generated.

Test Plan:
- Reset, then a comb op with req_comb_result = 0x3FF0000000000000 and flags 0 in cycle 1, out_ready = 1 → out_valid in cycle 2 with that result; occupancy returns to 0 in cycle 3.
- Dispatch A to unit 0 (tag 0), then B to unit 1 (tag 1). Unit 1 writes back first (result 0x2), unit 0 two cycles later (result 0x1) → outputs appear 0x1 then 0x2, and nothing is output before unit 0's writeback.
- Issue 4 ops with DEPTH = 4 and out_ready = 0 → req_ready = 0 at occupancy 4. Tags are 0,1,2,3. After one retire the next allocated tag is 0 (wrap).
- Hold out_ready = 0 for 3 cycles with head done, flags 0x10 → out_valid, out_result and out_flags stable for 3 cycles; retire happens on the first out_ready = 1.
- Assert clear with 3 entries pending and a wb_valid in the same cycle → next cycle occupancy = 0, out_valid = 0, and a new request receives tag 0.
- With FP_OOO_HUB_ERR_CHECK_EN, write back to tag 2 while empty → err = 1 next cycle and stays 1 until clear. Without the macro, err stays 0.
